mem_port_arbiter: RTL and testbench

- Shares one single-port memory (BRAM or SDRAM user port) between three requesters: Z80 CPU, ESP32 SPI loader and video fetch.
- Latches one-cycle request pulses, then arbitrates between them.
- Issues one access at a time to a fixed-latency memory port and returns data with a one-cycle ack per requester.
- Sits between the CPU/SPI/video logic and the RAM instance in the top level.

---
 rtl/mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency single-port memory between three requesters:
//   the Z80 CPU, the ESP32 SPI loader and the video fetch unit. One-cycle
//   request pulses are latched as pending flags. A winner is then chosen
//   (video first, CPU/SPI round-robin), and one access at a time is issued
//   to the memory. Each completion returns a one-cycle ack to its owner.
//
// Ports
//   clk_i, reset_n_i        clock, synchronous active-low reset
//   spi_load_i              loader mode: CPU held off (its request is kept)
//   cpu_req_i/we/addr/din   CPU access pulse and fields
//   cpu_dout_o, cpu_ack_o   CPU read data (held) and completion pulse
//   spi_*                   same set for the SPI loader
//   vid_req_i, vid_addr_i   video read pulse and address
//   vid_dout_o, vid_ack_o   video read data and completion pulse
//   mem_req_o/we/addr/din   memory strobe; addr/din held until completion
//   mem_dout_i              memory read data, sampled at completion
//   grant_o                 current owner: 0 none, 1 CPU, 2 SPI, 3 video
//   overrun_o               sticky: a request arrived while already pending
module mem_port_arbiter #(
    parameter int unsigned ADDR_BITS   = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 spi_load_i,

    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic [DATA_BITS-1:0] cpu_din_i,
    output logic [DATA_BITS-1:0] cpu_dout_o,
    output logic                 cpu_ack_o,

    input  logic                 spi_req_i,
    input  logic                 spi_we_i,
    input  logic [ADDR_BITS-1:0] spi_addr_i,
    input  logic [DATA_BITS-1:0] spi_din_i,
    output logic [DATA_BITS-1:0] spi_dout_o,
    output logic                 spi_ack_o,

    input  logic                 vid_req_i,
    input  logic [ADDR_BITS-1:0] vid_addr_i,
    output logic [DATA_BITS-1:0] vid_dout_o,
    output logic                 vid_ack_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DATA_BITS-1:0] mem_din_o,
    input  logic [DATA_BITS-1:0] mem_dout_i,

    output logic [1:0]           grant_o,
    output logic                 overrun_o
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_CPU  = 2'd1,
        G_SPI  = 2'd2,
        G_VID  = 2'd3
    } grant_e;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_e               state_q, state_d;
    grant_e               grant_q, grant_d;
    logic [3:0]           count_q, count_d;
    logic                 last_spi_q, last_spi_d;

    logic                 cpu_pend_q, cpu_pend_d;
    logic                 cpu_we_l_q, cpu_we_l_d;
    logic [ADDR_BITS-1:0] cpu_addr_l_q, cpu_addr_l_d;
    logic [DATA_BITS-1:0] cpu_din_l_q, cpu_din_l_d;

    logic                 spi_pend_q, spi_pend_d;
    logic                 spi_we_l_q, spi_we_l_d;
    logic [ADDR_BITS-1:0] spi_addr_l_q, spi_addr_l_d;
    logic [DATA_BITS-1:0] spi_din_l_q, spi_din_l_d;

    logic                 vid_pend_q, vid_pend_d;
    logic [ADDR_BITS-1:0] vid_addr_l_q, vid_addr_l_d;

    logic [DATA_BITS-1:0] cpu_dout_q, cpu_dout_d;
    logic [DATA_BITS-1:0] spi_dout_q, spi_dout_d;
    logic [DATA_BITS-1:0] vid_dout_q, vid_dout_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic                 spi_ack_q, spi_ack_d;
    logic                 vid_ack_q, vid_ack_d;

    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_din_q, mem_din_d;
    logic                 overrun_q, overrun_d;

    // Effective request fields: a pending request uses its latched copy,
    // a fresh pulse in this cycle uses the live inputs so it can win now.
    logic                 cpu_we_e, spi_we_e;
    logic [ADDR_BITS-1:0] cpu_addr_e, spi_addr_e, vid_addr_e;
    logic [DATA_BITS-1:0] cpu_din_e, spi_din_e;
    logic                 cpu_elig, spi_elig, vid_elig;

    always_comb begin
        cpu_we_e   = cpu_pend_q ? cpu_we_l_q   : cpu_we_i;
        cpu_addr_e = cpu_pend_q ? cpu_addr_l_q : cpu_addr_i;
        cpu_din_e  = cpu_pend_q ? cpu_din_l_q  : cpu_din_i;
        spi_we_e   = spi_pend_q ? spi_we_l_q   : spi_we_i;
        spi_addr_e = spi_pend_q ? spi_addr_l_q : spi_addr_i;
        spi_din_e  = spi_pend_q ? spi_din_l_q  : spi_din_i;
        vid_addr_e = vid_pend_q ? vid_addr_l_q : vid_addr_i;

        cpu_elig = (cpu_pend_q | cpu_req_i) & ~spi_load_i;
        spi_elig = spi_pend_q | spi_req_i;
        vid_elig = vid_pend_q | vid_req_i;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        count_d      = count_q;
        last_spi_d   = last_spi_q;
        cpu_pend_d   = cpu_pend_q;
        cpu_we_l_d   = cpu_we_l_q;
        cpu_addr_l_d = cpu_addr_l_q;
        cpu_din_l_d  = cpu_din_l_q;
        spi_pend_d   = spi_pend_q;
        spi_we_l_d   = spi_we_l_q;
        spi_addr_l_d = spi_addr_l_q;
        spi_din_l_d  = spi_din_l_q;
        vid_pend_d   = vid_pend_q;
        vid_addr_l_d = vid_addr_l_q;
        cpu_dout_d   = cpu_dout_q;
        spi_dout_d   = spi_dout_q;
        vid_dout_d   = vid_dout_q;
        cpu_ack_d    = 1'b0;
        spi_ack_d    = 1'b0;
        vid_ack_d    = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        overrun_d    = overrun_q;

        // Capture. A pulse while still pending keeps the old fields.
        if (cpu_req_i) begin
            if (cpu_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                cpu_pend_d   = 1'b1;
                cpu_we_l_d   = cpu_we_i;
                cpu_addr_l_d = cpu_addr_i;
                cpu_din_l_d  = cpu_din_i;
            end
        end
        if (spi_req_i) begin
            if (spi_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                spi_pend_d   = 1'b1;
                spi_we_l_d   = spi_we_i;
                spi_addr_l_d = spi_addr_i;
                spi_din_l_d  = spi_din_i;
            end
        end
        if (vid_req_i) begin
            if (vid_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                vid_pend_d   = 1'b1;
                vid_addr_l_d = vid_addr_i;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                grant_d = G_NONE;
                if (vid_elig) begin
                    grant_d    = G_VID;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = vid_addr_e;
                    mem_din_d  = '0;
                end else if (cpu_elig && (!spi_elig || last_spi_q)) begin
                    grant_d    = G_CPU;
                    mem_req_d  = 1'b1;
                    mem_we_d   = cpu_we_e;
                    mem_addr_d = cpu_addr_e;
                    mem_din_d  = cpu_din_e;
                    last_spi_d = 1'b0;
                end else if (spi_elig) begin
                    grant_d    = G_SPI;
                    mem_req_d  = 1'b1;
                    mem_we_d   = spi_we_e;
                    mem_addr_d = spi_addr_e;
                    mem_din_d  = spi_din_e;
                    last_spi_d = 1'b1;
                end
                if (mem_req_d) begin
                    count_d = LAT;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                count_d = count_q - 4'd1;
                // Completion edge; the pending clear here overrides any
                // capture above (which could only have flagged overrun).
                if (count_q == 4'd1) begin
                    unique case (grant_q)
                        G_CPU: begin
                            if (!mem_we_q) cpu_dout_d = mem_dout_i;
                            cpu_ack_d  = 1'b1;
                            cpu_pend_d = 1'b0;
                        end
                        G_SPI: begin
                            if (!mem_we_q) spi_dout_d = mem_dout_i;
                            spi_ack_d  = 1'b1;
                            spi_pend_d = 1'b0;
                        end
                        G_VID: begin
                            vid_dout_d = mem_dout_i;
                            vid_ack_d  = 1'b1;
                            vid_pend_d = 1'b0;
                        end
                        default: ;
                    endcase
                    grant_d = G_NONE;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            grant_q      <= G_NONE;
            count_q      <= '0;
            last_spi_q   <= 1'b1;
            cpu_pend_q   <= 1'b0;
            cpu_we_l_q   <= 1'b0;
            cpu_addr_l_q <= '0;
            cpu_din_l_q  <= '0;
            spi_pend_q   <= 1'b0;
            spi_we_l_q   <= 1'b0;
            spi_addr_l_q <= '0;
            spi_din_l_q  <= '0;
            vid_pend_q   <= 1'b0;
            vid_addr_l_q <= '0;
            cpu_dout_q   <= '0;
            spi_dout_q   <= '0;
            vid_dout_q   <= '0;
            cpu_ack_q    <= 1'b0;
            spi_ack_q    <= 1'b0;
            vid_ack_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            count_q      <= count_d;
            last_spi_q   <= last_spi_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_we_l_q   <= cpu_we_l_d;
            cpu_addr_l_q <= cpu_addr_l_d;
            cpu_din_l_q  <= cpu_din_l_d;
            spi_pend_q   <= spi_pend_d;
            spi_we_l_q   <= spi_we_l_d;
            spi_addr_l_q <= spi_addr_l_d;
            spi_din_l_q  <= spi_din_l_d;
            vid_pend_q   <= vid_pend_d;
            vid_addr_l_q <= vid_addr_l_d;
            cpu_dout_q   <= cpu_dout_d;
            spi_dout_q   <= spi_dout_d;
            vid_dout_q   <= vid_dout_d;
            cpu_ack_q    <= cpu_ack_d;
            spi_ack_q    <= spi_ack_d;
            vid_ack_q    <= vid_ack_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cpu_dout_o = cpu_dout_q;
    assign cpu_ack_o  = cpu_ack_q;
    assign spi_dout_o = spi_dout_q;
    assign spi_ack_o  = spi_ack_q;
    assign vid_dout_o = vid_dout_q;
    assign vid_ack_o  = vid_ack_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign grant_o    = grant_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_load = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        spi_req = 1'b0, spi_we = 1'b0;
    logic [15:0] spi_addr = '0;
    logic [7:0]  spi_din = '0;
    logic [7:0]  spi_dout;
    logic        spi_ack;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic [7:0]  vid_dout;
    logic        vid_ack;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = '0;
    logic [1:0]  grant;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    // Model memory: write on strobe, registered read of the held address
    // (data valid one cycle after mem_req, sampled at completion for latency 2).
    always @(posedge clk) begin
        if (mem_req && mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    mem_port_arbiter #(
        .ADDR_BITS(16),
        .DATA_BITS(8),
        .MEM_LATENCY(2)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .spi_load_i(spi_load),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout), .cpu_ack_o(cpu_ack),
        .spi_req_i(spi_req), .spi_we_i(spi_we), .spi_addr_i(spi_addr),
        .spi_din_i(spi_din), .spi_dout_o(spi_dout), .spi_ack_o(spi_ack),
        .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_dout_o(vid_dout),
        .vid_ack_o(vid_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_din_o(mem_din), .mem_dout_i(mem_dout),
        .grant_o(grant), .overrun_o(overrun)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int spi_acks;
        int cpu_seen;
        logic got;

        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int spi_acks;
        int cpu_seen;
        logic got;

        mem[16'h1234] = 8'hA5;

        // Reset state
        tick(2);
        check("rst_mem_req", mem_req, 0);
        check("rst_grant", grant, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_acks", {cpu_ack, spi_ack, vid_ack}, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        tick();

        // T1: uncontended CPU read of 0x1234
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        tick();
        cpu_req = 0;
        check("t1_mem_req_c1", mem_req, 1);
        check("t1_mem_addr_c1", mem_addr, 16'h1234);
        check("t1_mem_we_c1", mem_we, 0);
        check("t1_grant_c1", grant, 1);
        tick();
        check("t1_mem_req_c2", mem_req, 0);
        check("t1_grant_c2", grant, 1);
        check("t1_ack_c2", cpu_ack, 0);
        tick();
        check("t1_ack_c3", cpu_ack, 1);
        check("t1_dout_c3", cpu_dout, 8'hA5);
        tick();
        check("t1_ack_c4", cpu_ack, 0);
        check("t1_grant_c4", grant, 0);

        // T2: CPU read + SPI write together after reset -> CPU first
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        spi_req = 1; spi_we = 1; spi_addr = 16'h0100; spi_din = 8'h5A;
        tick();
        cpu_req = 0; spi_req = 0;
        check("t2_grant_c1", grant, 1);
        tick(2);
        check("t2_cpu_ack_c3", cpu_ack, 1);
        tick();
        check("t2_spi_mem_req_c4", mem_req, 1);
        check("t2_grant_c4", grant, 2);
        check("t2_mem_addr_c4", mem_addr, 16'h0100);
        check("t2_mem_we_c4", mem_we, 1);
        check("t2_mem_din_c4", mem_din, 8'h5A);
        tick(2);
        check("t2_spi_ack_c6", spi_ack, 1);
        check("t2_spi_dout_write", spi_dout, 0);
        check("t2_mem_0100", mem[16'h0100], 8'h5A);
        tick();

        // T3: CPU alone reads back 0x0100 (CPU now last winner)
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        tick();
        cpu_req = 0;
        tick(2);
        check("t3_cpu_ack", cpu_ack, 1);
        check("t3_cpu_dout", cpu_dout, 8'h5A);
        tick();

        // T4: both again -> SPI first by round-robin
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        spi_req = 1; spi_we = 1; spi_addr = 16'h0200; spi_din = 8'h33;
        tick();
        cpu_req = 0; spi_req = 0;
        check("t4_grant_c1", grant, 2);
        tick(2);
        check("t4_spi_ack_c3", spi_ack, 1);
        check("t4_cpu_ack_c3", cpu_ack, 0);
        tick();
        check("t4_grant_c4", grant, 1);
        tick(2);
        check("t4_cpu_ack_c6", cpu_ack, 1);
        check("t4_cpu_dout", cpu_dout, 8'hA5);
        check("t4_mem_0200", mem[16'h0200], 8'h33);

        // T5: video, CPU, SPI all at once -> video, CPU, SPI
        do_reset();
        vid_req = 1; vid_addr = 16'h1234;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        spi_req = 1; spi_we = 1; spi_addr = 16'h0300; spi_din = 8'h77;
        tick();
        vid_req = 0; cpu_req = 0; spi_req = 0;
        check("t5_grant_c1", grant, 3);
        check("t5_addr_c1", mem_addr, 16'h1234);
        tick(2);
        check("t5_vid_ack_c3", vid_ack, 1);
        check("t5_vid_dout", vid_dout, 8'hA5);
        tick();
        check("t5_grant_c4", grant, 1);
        check("t5_addr_c4", mem_addr, 16'h0100);
        tick(2);
        check("t5_cpu_ack_c6", cpu_ack, 1);
        check("t5_cpu_dout", cpu_dout, 8'h5A);
        tick();
        check("t5_grant_c7", grant, 2);
        check("t5_addr_c7", mem_addr, 16'h0300);
        tick(2);
        check("t5_spi_ack_c9", spi_ack, 1);
        check("t5_spi_dout", spi_dout, 0);
        check("t5_mem_0300", mem[16'h0300], 8'h77);
        check("t5_overrun", overrun, 0);

        // T6: loader mode holds off the CPU for 10 SPI writes
        spi_load = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        tick();
        cpu_req = 0;
        cpu_seen = 0;
        spi_acks = 0;
        if (cpu_ack || grant == 2'd1) cpu_seen++;
        for (int i = 0; i < 10; i++) begin
            spi_req = 1; spi_we = 1; spi_addr = 16'h1000 + 16'(i); spi_din = 8'(i);
            tick();
            spi_req = 0;
            got = 0;
            if (cpu_ack || grant == 2'd1) cpu_seen++;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (cpu_ack || grant == 2'd1) cpu_seen++;
                if (spi_ack) begin
                    got = 1;
                    break;
                end
            end
            if (got) spi_acks++;
        end
        check("t6_spi_acks", spi_acks, 10);
        check("t6_no_cpu_in_load", cpu_seen, 0);
        check("t6_mem_1009", mem[16'h1009], 8'h09);
        spi_load = 0;
        tick();
        check("t6_grant_c1", grant, 1);
        check("t6_addr_c1", mem_addr, 16'h1234);
        tick();
        check("t6_cpu_ack_c2", cpu_ack, 0);
        tick();
        check("t6_cpu_ack_c3", cpu_ack, 1);
        check("t6_cpu_dout", cpu_dout, 8'hA5);
        tick();

        // T7: second CPU pulse while pending -> overrun, original served
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        tick();
        cpu_addr = 16'h1234;
        tick();
        cpu_req = 0;
        check("t7_overrun_c2", overrun, 1);
        check("t7_addr_c2", mem_addr, 16'h0100);
        tick();
        check("t7_cpu_ack_c3", cpu_ack, 1);
        check("t7_cpu_dout", cpu_dout, 8'h5A);
        tick();
        check("t7_no_mem_req_c4", mem_req, 0);
        check("t7_grant_c4", grant, 0);
        tick(2);
        check("t7_grant_c6", grant, 0);
        check("t7_overrun_sticky", overrun, 1);
        reset_n = 0;
        tick();
        check("t7_overrun_reset", overrun, 0);
        reset_n = 1;
        tick();

        // T8: reset while BUSY abandons the access
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        tick();
        cpu_req = 0;
        check("t8_mem_req_c1", mem_req, 1);
        tick();
        reset_n = 0;
        tick();
        check("t8_ack_in_reset", cpu_ack, 0);
        check("t8_mem_req_rst", mem_req, 0);
        check("t8_grant_rst", grant, 0);
        check("t8_dout_rst", cpu_dout, 0);
        reset_n = 1;
        tick();
        check("t8_ack_after_rst", cpu_ack, 0);
        check("t8_grant_after_rst", grant, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        tick();
        cpu_req = 0;
        check("t8_new_grant", grant, 1);
        tick(2);
        check("t8_new_ack", cpu_ack, 1);
        check("t8_new_dout", cpu_dout, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
